ram_fill_sequencer: RTL and testbench
=====================================

# ram_fill_sequencer

Parametrised RAM pattern writer for the display/cellular-automaton frame memory: on a start pulse it walks an address window, writing one generated data word per address through a valid/ready write port. It supports incrementing, constant and pseudo-random (LFSR) patterns, programmable inter-write spacing, single-pass or looping operation, and abort. It sits between control logic and the video RAM write port, and replaces the free-running address/data counter used for initial memory fill.

## Interface
- ADDR_W, 10, RAM address width
- DATA_W, 8, RAM data width (1..16 when LFSR mode is compiled in)
- BASE, 0, first address of the window
- LAST, 2**ADDR_W-1, last address of the window; BASE <= LAST required
- GAP, 0, idle cycles inserted after each accepted write (0 = back-to-back)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; honoured only in IDLE
- abort  in  1  stop current pass, no done pulse
- mode  in  2  00 INC, 01 CONST, 10 LFSR, 11 reserved (treated as CONST)
- fill_value  in  DATA_W  seed / constant
- loop  in  1  1 = restart at BASE after LAST
- ram_ready  in  1  write port accepts when high
- ram_we  out  1  write valid
- ram_addr  out  ADDR_W  write address
- ram_data  out  DATA_W  write data
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse per completed pass

## Operation
- States: IDLE, WRITE, GAP. All outputs registered.
- IDLE: ram_we=0, busy=0. On start: latch mode, fill_value, loop; ram_addr<=BASE; load generator; go WRITE.
- WRITE: ram_we=1; ram_addr/ram_data held stable until ram_we&&ram_ready at a clock edge (accept).
- On accept: advance generator; if GAP>0 go GAP (ram_we=0) for exactly GAP cycles, else stay WRITE with next word.
- Next address: ram_addr+1, or BASE after LAST (no ADDR_W overflow ever reached beyond LAST).
- Accept at LAST: done=1 next cycle; if latched loop=0 go IDLE (busy=0 same cycle as done); if loop=1 continue with BASE (after GAP), busy stays 1.
- Generators: INC data = fill_value + index, modulo 2^DATA_W, index restarts at 0 each pass. CONST data = fill_value. LFSR: 16-bit Galois, right shift, XOR 16'hB400 when shifted-out bit is 1; seed = {fill_value, ~fill_value} truncated/zero-extended to 16 bits, forced to 16'h0001 if zero; data = state[DATA_W-1:0]; not reseeded between looped passes.
- abort (any state): next cycle IDLE, ram_we=0, no done; abort has priority over accept and start in the same cycle (the coinciding accept still counts as a write at the RAM).
- start while busy: ignored. mode/fill_value/loop changes while busy: ignored until next start.

## Timing
- Reset values: ram_we=0, ram_addr=BASE, ram_data=0, busy=0, done=0, state IDLE, LFSR=16'h0001.
- start at edge t -> ram_we=1, ram_addr=BASE, first data visible after edge t (cycle t+1).
- GAP=0, ram_ready=1: one write per cycle; pass of N=LAST-BASE+1 words takes N cycles; done in cycle after final accept.
- GAP=g: accepts spaced g+1 cycles apart when ram_ready=1.
- ram_ready low: all write outputs frozen; no generator advance.
- reset asserted mid-pass: immediate return to reset values.

## Configuration
- RAM_FILL_LFSR_EN defined: LFSR generator and mode 10 as above; DATA_W <= 16.
- Not defined: no LFSR logic; mode 10 behaves as INC; no DATA_W limit.

## Test plan
- ADDR_W=4, BASE=2, LAST=5, GAP=0, INC, fill_value=8'hFE, ram_ready=1 -> writes (2,FE),(3,FF),(4,00),(5,01) on consecutive cycles; done one cycle after; busy low with done.
- Same, CONST 8'h3C, ram_ready low for 3 cycles at address 3 -> address 3/data 3C held 3 extra cycles, exactly 4 writes total.
- GAP=2, loop=1 -> accepts every 3 cycles, address 5 followed by 2 (after gap), done pulses each pass, busy never drops; abort -> IDLE next cycle, no done.
- LFSR (macro on), DATA_W=8, fill_value=8'h00 -> seed 16'h00FF, first data FF, second data = low byte of (16'h00FF>>1)^16'hB400 = 8'h7F.
- Macro off, mode 10 -> identical writes to INC test.
- rst_n low at third write -> all outputs to reset values asynchronously; start pulse during busy -> no restart.

Source files
------------

// File: rtl/ram_fill_sequencer.sv
// ram_fill_sequencer: walks BASE..LAST writing one generated word per address.
// Optional LFSR pattern generator enabled by defining RAM_FILL_LFSR_EN.
module ram_fill_sequencer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int BASE   = 0,
    parameter int LAST   = 2**ADDR_W-1,
    parameter int GAP    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              loop,
    input  logic              ram_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0]     GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(LAST);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic              loop_q, loop_d;
    logic [GW-1:0]     gcnt_q, gcnt_d;
    logic              accept;
    logic              wrap;

`ifdef RAM_FILL_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] lfsr_nx;
    logic [15:0] seed;

    function automatic logic [15:0] lfsr_seed(input logic [DATA_W-1:0] v);
        logic [2*DATA_W-1:0] cat;
        logic [15:0]         s;
        cat = {v, ~v};
        s   = 16'(cat);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction
`endif

    assign accept = we_q & ram_ready;
    assign wrap   = (addr_q == LAST_A);

    // Next-state, next-word and handshake decode; abort overrides everything
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mode_d  = mode_q;
        fill_d  = fill_q;
        loop_d  = loop_q;
        gcnt_d  = gcnt_q;
`ifdef RAM_FILL_LFSR_EN
        lfsr_d  = lfsr_q;
        lfsr_nx = lfsr_step(lfsr_q);
        seed    = lfsr_seed(fill_value);
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    fill_d  = fill_value;
                    loop_d  = loop;
                    addr_d  = BASE_A;
                    data_d  = fill_value;
`ifdef RAM_FILL_LFSR_EN
                    lfsr_d  = seed;
                    if (mode == 2'b10) begin
                        data_d = seed[DATA_W-1:0];
                    end
`endif
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (accept) begin
                    addr_d = wrap ? BASE_A : addr_q + ADDR_W'(1);
`ifdef RAM_FILL_LFSR_EN
                    if (mode_q == 2'b10) begin
                        lfsr_d = lfsr_nx;
                        data_d = lfsr_nx[DATA_W-1:0];
                    end else
`endif
                    if (mode_q == 2'b00 || mode_q == 2'b10) begin
                        data_d = wrap ? fill_q : data_q + DATA_W'(1);
                    end else begin
                        data_d = fill_q;
                    end
                    done_d = wrap;
                    if (wrap && !loop_q) begin
                        we_d    = 1'b0;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else if (GAP > 0) begin
                        we_d    = 1'b0;
                        gcnt_d  = GAP_LOAD;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gcnt_q == '0) begin
                    we_d    = 1'b1;
                    state_d = S_WRITE;
                end else begin
                    gcnt_d = gcnt_q - GW'(1);
                end
            end
            default: begin
                we_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        if (abort) begin
            we_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            state_d = S_IDLE;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= BASE_A;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= 2'b00;
            fill_q  <= '0;
            loop_q  <= 1'b0;
            gcnt_q  <= '0;
`ifdef RAM_FILL_LFSR_EN
            lfsr_q  <= 16'h0001;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            loop_q  <= loop_d;
            gcnt_q  <= gcnt_d;
`ifdef RAM_FILL_LFSR_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    assign ram_we   = we_q;
    assign ram_addr = addr_q;
    assign ram_data = data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ram_fill_sequencer.sv
// tb_ram_fill_sequencer: directed checks on a GAP=0 and a GAP=2 instance.
// Window is BASE=2..LAST=5 on a 4-bit address, 8-bit data.
module tb_ram_fill_sequencer;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start0 = 1'b0, abort0 = 1'b0;
    logic          start2 = 1'b0, abort2 = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [DW-1:0] fill = '0;
    logic          loop = 1'b0;
    logic          ready = 1'b1;

    logic          we0, busy0, done0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] data0;
    logic          we2, busy2, done2;
    logic [AW-1:0] addr2;
    logic [DW-1:0] data2;

    int checks = 0;
    int failures = 0;
    int wr0 = 0;
    int wr2 = 0;
    int w;

    logic [7:0] exp_a [4];
    logic [7:0] exp_d [4];

    ram_fill_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .BASE(2), .LAST(5), .GAP(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .mode(mode), .fill_value(fill), .loop(loop),
        .ram_ready(ready), .ram_we(we0), .ram_addr(addr0),
        .ram_data(data0), .busy(busy0), .done(done0)
    );

    ram_fill_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .BASE(2), .LAST(5), .GAP(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .mode(mode), .fill_value(fill), .loop(loop),
        .ram_ready(ready), .ram_we(we2), .ram_addr(addr2),
        .ram_data(data2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    // Count writes accepted at the RAM
    always @(posedge clk) begin
        if (we0 && ready) wr0 <= wr0 + 1;
        if (we2 && ready) wr2 <= wr2 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input int which, input string tag,
                           input logic e_we, input logic e_busy,
                           input logic e_done);
        if (which == 0) begin
            chk({tag, ".we"}, 32'(we0), 32'(e_we));
            chk({tag, ".busy"}, 32'(busy0), 32'(e_busy));
            chk({tag, ".done"}, 32'(done0), 32'(e_done));
        end else begin
            chk({tag, ".we"}, 32'(we2), 32'(e_we));
            chk({tag, ".busy"}, 32'(busy2), 32'(e_busy));
            chk({tag, ".done"}, 32'(done2), 32'(e_done));
        end
    endtask

    task automatic chk_wr(input int which, input string tag,
                          input logic [31:0] e_a, input logic [31:0] e_d);
        if (which == 0) begin
            chk({tag, ".addr"}, 32'(addr0), e_a);
            chk({tag, ".data"}, 32'(data0), e_d);
        end else begin
            chk({tag, ".addr"}, 32'(addr2), e_a);
            chk({tag, ".data"}, 32'(data2), e_d);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_ctl(0, "rst0", 1'b0, 1'b0, 1'b0);
        chk_wr(0, "rst0", 2, 0);
        chk_ctl(2, "rst2", 1'b0, 1'b0, 1'b0);
        chk_wr(2, "rst2", 2, 0);
        rst_n = 1'b1;
        tick;

        // INC from FE, wraps modulo 256; input changes after start ignored
        exp_a = '{8'd2, 8'd3, 8'd4, 8'd5};
        exp_d = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        w = wr0;
        mode = 2'b00; fill = 8'hFE; loop = 1'b0; start0 = 1'b1;
        tick;
        start0 = 1'b0; mode = 2'b01; fill = 8'h00;
        for (int i = 0; i < 4; i++) begin
            chk_ctl(0, $sformatf("inc%0d", i), 1'b1, 1'b1, 1'b0);
            chk_wr(0, $sformatf("inc%0d", i), 32'(exp_a[i]), 32'(exp_d[i]));
            tick;
        end
        chk_ctl(0, "inc_done", 1'b0, 1'b0, 1'b1);
        chk("inc_writes", 32'(wr0 - w), 4);
        tick;
        chk_ctl(0, "inc_idle", 1'b0, 1'b0, 1'b0);

        // CONST with ready low for 3 cycles at address 3
        w = wr0;
        mode = 2'b01; fill = 8'h3C; start0 = 1'b1;
        tick;
        start0 = 1'b0;
        chk_wr(0, "const0", 2, 8'h3C);
        tick;
        chk_wr(0, "const1", 3, 8'h3C);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_ctl(0, $sformatf("stall%0d", i), 1'b1, 1'b1, 1'b0);
            chk_wr(0, $sformatf("stall%0d", i), 3, 8'h3C);
        end
        ready = 1'b1;
        tick;
        chk_wr(0, "const2", 4, 8'h3C);
        tick;
        chk_wr(0, "const3", 5, 8'h3C);
        tick;
        chk_ctl(0, "const_done", 1'b0, 1'b0, 1'b1);
        chk("const_writes", 32'(wr0 - w), 4);

        // GAP=2 looping INC from 10; start while busy must be ignored
        w = wr2;
        mode = 2'b00; fill = 8'h10; loop = 1'b1; start2 = 1'b1;
        tick;
        start2 = 1'b0;
        for (int k = 0; k < 27; k++) begin
            chk_ctl(2, $sformatf("gap%0d", k), 1'((k % 3) == 0), 1'b1,
                    1'((k % 12) == 10));
            if ((k % 3) == 0)
                chk_wr(2, $sformatf("gap%0d", k), 32'(2 + (k / 3) % 4),
                       32'(8'h10 + (k / 3) % 4));
            start2 = (k == 4);
            tick;
        end
        chk_ctl(2, "gap27", 1'b1, 1'b1, 1'b0);
        chk_wr(2, "gap27", 3, 8'h11);
        abort2 = 1'b1;
        tick;
        abort2 = 1'b0;
        chk_ctl(2, "abort", 1'b0, 1'b0, 1'b0);
        chk("abort_writes", 32'(wr2 - w), 10);
        tick;
        chk_ctl(2, "abort_idle", 1'b0, 1'b0, 1'b0);
        loop = 1'b0;

        // Mode 10: LFSR when compiled in, otherwise behaves as INC
`ifdef RAM_FILL_LFSR_EN
        fill = 8'h00;
        exp_d = '{8'hFF, 8'h7F, 8'h3F, 8'h1F};
`else
        fill = 8'hFE;
        exp_d = '{8'hFE, 8'hFF, 8'h00, 8'h01};
`endif
        mode = 2'b10; start0 = 1'b1;
        tick;
        start0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_wr(0, $sformatf("m10_%0d", i), 32'(exp_a[i]), 32'(exp_d[i]));
            tick;
        end
        chk_ctl(0, "m10_done", 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a pass
        mode = 2'b00; fill = 8'h40; start0 = 1'b1;
        tick;
        start0 = 1'b0;
        tick;
        tick;
        chk_wr(0, "pre_rst", 4, 8'h42);
        #2 rst_n = 1'b0;
        #1;
        chk_ctl(0, "arst", 1'b0, 1'b0, 1'b0);
        chk_wr(0, "arst", 2, 0);
        #2 rst_n = 1'b1;
        tick;
        chk_ctl(0, "post_rst", 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
